mc_ctrl_fsm: RTL and testbench

Multicycle main controller that sequences the shared datapath: PC, instruction/data memory port, register file and the 6-bit-opcode ALU. It decodes the latched instruction's opcode/funct fields and walks a Moore state machine through fetch, decode, execute, memory and write-back. It emits every datapath enable and mux select each cycle, plus the ALU operation code. It sits between the instruction register and the datapath inside the CPU top level.

---
 rtl/mc_ctrl_fsm.sv | 240 ++++++++++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle main controller for the shared CPU datapath.
// Moore FSM walking fetch/decode/execute/memory/write-back, emitting every
// datapath enable, mux select and the 6-bit ALU operation each cycle.
// Optional build macro: MC_CTRL_MEM_WAIT_EN -- FETCH, MEM_RD and MEM_WR
// stretch until mem_ready is high; without it mem_ready is ignored.
//
// state    | code | meaning
// ---------+------+----------------------------------------------------
// FETCH    |  0   | read instruction at PC, load IR, PC <= PC + 4
// DECODE   |  1   | branch target into ALUOut, dispatch on opcode
// MEM_ADDR |  2   | effective address A + sign-extended immediate
// MEM_RD   |  3   | load data read at ALUOut into MDR
// MEM_WB   |  4   | MDR written to register rt
// MEM_WR   |  5   | store B at ALUOut
// EXEC_R   |  6   | R-type ALU operation selected by funct
// R_WB     |  7   | ALUOut written to register rd
// EXEC_I   |  8   | immediate ALU operation selected by opcode
// I_WB     |  9   | ALUOut written to register rt
// BRANCH   | 10   | bgtz: PC <= ALUOut when A > 0
// JUMP     | 11   | PC <= jump target
// 12..15   |  -   | unreachable, recover to FETCH
module mc_ctrl_fsm #(
  parameter int INSTR_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   alu_zero,
  input  logic                   mem_ready,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic                   i_or_d,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   reg_write,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic [1:0]             pc_source,
  output logic [5:0]             alu_op,
  output logic [3:0]             state,
  output logic                   illegal,
  output logic [INSTR_CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] ALU_NOP = 6'b000000;
  localparam logic [5:0] ALU_ADD = 6'b100000;
  localparam logic [5:0] ALU_SUB = 6'b100010;
  localparam logic [5:0] ALU_AND = 6'b100100;
  localparam logic [5:0] ALU_OR  = 6'b100101;
  localparam logic [5:0] ALU_XOR = 6'b100110;
  localparam logic [5:0] ALU_NOR = 6'b100111;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t                 r_state;
  state_t                 w_next_state;
  logic                   w_retire;
  logic                   w_mem_go;
  logic                   w_funct_ok;
  logic [INSTR_CNT_W-1:0] r_instr_count;

  // alu_zero qualifies pc_write_cond outside this block; it is a port for
  // completeness of the datapath bundle only.
  logic w_unused;
  assign w_unused = ^{alu_zero, mem_ready};

`ifdef MC_CTRL_MEM_WAIT_EN
  assign w_mem_go = mem_ready;
`else
  assign w_mem_go = 1'b1;
`endif

  // Legal R-type funct codes are exactly the six ALU operations.
  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_NOR: w_funct_ok = 1'b1;
      default:                                             w_funct_ok = 1'b0;
    endcase
  end

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_FETCH;
    else     r_state <= w_next_state;
  end

  // Next-state and Moore control decode; illegal also looks at opcode/funct.
  always_comb begin
    w_next_state  = S_FETCH;
    w_retire      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    pc_source     = 2'd0;
    alu_op        = ALU_NOP;
    illegal       = 1'b0;
    case (r_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        alu_op    = ALU_ADD;
        // Gating the loads while memory stalls keeps PC from advancing twice.
        ir_write  = w_mem_go;
        pc_write  = w_mem_go;
        w_next_state = w_mem_go ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_RTYPE:                         w_next_state = S_EXEC_R;
          OP_LW, OP_SW:                     w_next_state = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: w_next_state = S_EXEC_I;
          OP_BGTZ:                          w_next_state = S_BRANCH;
          OP_J:                             w_next_state = S_JUMP;
          default: begin
            w_next_state = S_FETCH;
            illegal      = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'd2;
        alu_op       = ALU_ADD;
        w_next_state = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        i_or_d       = 1'b1;
        mem_read     = 1'b1;
        w_next_state = w_mem_go ? S_MEM_WB : S_MEM_RD;
      end
      S_MEM_WB: begin
        reg_write    = 1'b1;
        mem_to_reg   = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_MEM_WR: begin
        i_or_d       = 1'b1;
        mem_write    = 1'b1;
        w_retire     = w_mem_go;
        w_next_state = w_mem_go ? S_FETCH : S_MEM_WR;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        if (w_funct_ok) begin
          alu_op       = funct;
          w_next_state = S_R_WB;
        end else begin
          illegal      = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_R_WB: begin
        reg_write    = 1'b1;
        reg_dst      = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        case (opcode)
          OP_ADDI: alu_op = ALU_ADD;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          OP_XORI: alu_op = ALU_XOR;
          default: alu_op = ALU_NOP;
        endcase
        w_next_state = S_I_WB;
      end
      S_I_WB: begin
        reg_write    = 1'b1;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        w_retire      = 1'b1;
        w_next_state  = S_FETCH;
      end
      S_JUMP: begin
        pc_write     = 1'b1;
        pc_source    = 2'd2;
        w_retire     = 1'b1;
        w_next_state = S_FETCH;
      end
      default: w_next_state = S_FETCH;
    endcase
  end

  // Retired-instruction counter; wraps naturally at its width.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_instr_count <= '0;
    else if (w_retire) r_instr_count <= r_instr_count + INSTR_CNT_W'(1);
  end

  assign state       = r_state;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb_mc_ctrl_fsm: directed instruction sequences; the driver queues the
// expected per-cycle controller response, a negedge monitor checks it.
`timescale 1ns/1ps
module tb_mc_ctrl_fsm;

  localparam logic [5:0] NOP  = 6'b000000;
  localparam logic [5:0] ADD  = 6'b100000;
  localparam logic [5:0] SUB  = 6'b100010;
  localparam logic [5:0] AND_ = 6'b100100;
  localparam logic [5:0] OR_  = 6'b100101;
  localparam logic [5:0] XOR_ = 6'b100110;
  localparam logic [5:0] NOR_ = 6'b100111;

  // ctrl bit order: pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
  // ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a | alu_src_b | pc_source
  localparam logic [13:0] C_FETCH  = {10'b1001010000, 2'd1, 2'd0};
  localparam logic [13:0] C_FETCHW = {10'b0001000000, 2'd1, 2'd0};
  localparam logic [13:0] C_DECODE = {10'b0000000000, 2'd3, 2'd0};
  localparam logic [13:0] C_MADDR  = {10'b0000000001, 2'd2, 2'd0};
  localparam logic [13:0] C_MRD    = {10'b0011000000, 2'd0, 2'd0};
  localparam logic [13:0] C_MWB    = {10'b0000000110, 2'd0, 2'd0};
  localparam logic [13:0] C_MWR    = {10'b0010100000, 2'd0, 2'd0};
  localparam logic [13:0] C_EXR    = {10'b0000000001, 2'd0, 2'd0};
  localparam logic [13:0] C_RWB    = {10'b0000001010, 2'd0, 2'd0};
  localparam logic [13:0] C_EXI    = {10'b0000000001, 2'd2, 2'd0};
  localparam logic [13:0] C_IWB    = {10'b0000000010, 2'd0, 2'd0};
  localparam logic [13:0] C_BR     = {10'b0100000001, 2'd0, 2'd1};
  localparam logic [13:0] C_JMP    = {10'b1000000000, 2'd0, 2'd2};

  typedef struct packed {
    logic [3:0]  st;
    logic [13:0] ctrl;
    logic [5:0]  op;
    logic        ill;
    logic [31:0] cnt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  opcode = 6'd0;
  logic [5:0]  funct = 6'd0;
  logic        alu_zero = 1'b0;
  logic        mem_ready = 1'b1;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        reg_dst, mem_to_reg, reg_write, alu_src_a, illegal;
  logic [1:0]  alu_src_b, pc_source;
  logic [5:0]  alu_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  exp_t  q_exp[$];
  string q_name[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    cnt = 0;

  mc_ctrl_fsm #(.INSTR_CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .pc_source(pc_source),
    .alu_op(alu_op), .state(state), .illegal(illegal),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic push(input string nm, input logic [3:0] st,
                      input logic [13:0] ctrl, input logic [5:0] op,
                      input logic ill);
    exp_t e;
    e.st = st; e.ctrl = ctrl; e.op = op; e.ill = ill; e.cnt = cnt;
    q_exp.push_back(e);
    q_name.push_back(nm);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cnt = 0;
    #1;
    push("reset", 4'd0, C_FETCH, ADD, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic rtype(input string nm, input logic [5:0] fn);
    opcode = 6'b000000; funct = fn;
    push(nm, 4'd0, C_FETCH, ADD, 1'b0);
    push(nm, 4'd1, C_DECODE, ADD, 1'b0);
    push(nm, 4'd6, C_EXR, fn, 1'b0);
    push(nm, 4'd7, C_RWB, NOP, 1'b0);
    step(4);
    cnt++;
  endtask

  task automatic itype(input string nm, input logic [5:0] op, input logic [5:0] aop);
    opcode = op; funct = 6'b010101;
    push(nm, 4'd0, C_FETCH, ADD, 1'b0);
    push(nm, 4'd1, C_DECODE, ADD, 1'b0);
    push(nm, 4'd8, C_EXI, aop, 1'b0);
    push(nm, 4'd9, C_IWB, NOP, 1'b0);
    step(4);
    cnt++;
  endtask

  task automatic lw_seq(input string nm);
    opcode = 6'b100011;
    push(nm, 4'd0, C_FETCH, ADD, 1'b0);
    push(nm, 4'd1, C_DECODE, ADD, 1'b0);
    push(nm, 4'd2, C_MADDR, ADD, 1'b0);
    push(nm, 4'd3, C_MRD, NOP, 1'b0);
    push(nm, 4'd4, C_MWB, NOP, 1'b0);
    step(5);
    cnt++;
  endtask

  // Monitor: one expected record per cycle while any are queued.
  always @(negedge clk) begin
    if (q_exp.size() > 0) begin
      exp_t  e;
      exp_t  g;
      string nm;
      e  = q_exp.pop_front();
      nm = q_name.pop_front();
      g.st   = state;
      g.ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source};
      g.op   = alu_op;
      g.ill  = illegal;
      g.cnt  = instr_count;
      n_checks++;
      if (g !== e) begin
        n_fail++;
        $display("FAIL %s @%0t: got state=%0d ctrl=%b alu_op=%b illegal=%b count=%0d, need state=%0d ctrl=%b alu_op=%b illegal=%b count=%0d",
                 nm, $time, g.st, g.ctrl, g.op, g.ill, g.cnt,
                 e.st, e.ctrl, e.op, e.ill, e.cnt);
      end
    end
  end

  initial begin
    do_reset();

    rtype("add", ADD);
    lw_seq("lw");

    opcode = 6'b101011;
    push("sw", 4'd0, C_FETCH, ADD, 1'b0);
    push("sw", 4'd1, C_DECODE, ADD, 1'b0);
    push("sw", 4'd2, C_MADDR, ADD, 1'b0);
    push("sw", 4'd5, C_MWR, NOP, 1'b0);
    step(4);
    cnt++;

    alu_zero = 1'b1;
    opcode = 6'b000111;
    push("bgtz_t", 4'd0, C_FETCH, ADD, 1'b0);
    push("bgtz_t", 4'd1, C_DECODE, ADD, 1'b0);
    push("bgtz_t", 4'd10, C_BR, NOP, 1'b0);
    step(3);
    cnt++;
    alu_zero = 1'b0;
    push("bgtz_f", 4'd0, C_FETCH, ADD, 1'b0);
    push("bgtz_f", 4'd1, C_DECODE, ADD, 1'b0);
    push("bgtz_f", 4'd10, C_BR, NOP, 1'b0);
    step(3);
    cnt++;

    opcode = 6'b000010;
    push("j", 4'd0, C_FETCH, ADD, 1'b0);
    push("j", 4'd1, C_DECODE, ADD, 1'b0);
    push("j", 4'd11, C_JMP, NOP, 1'b0);
    step(3);
    cnt++;

    opcode = 6'b111111;
    push("bad_op", 4'd0, C_FETCH, ADD, 1'b0);
    push("bad_op", 4'd1, C_DECODE, ADD, 1'b1);
    step(2);

    opcode = 6'b000000; funct = 6'b000011;
    push("bad_fn", 4'd0, C_FETCH, ADD, 1'b0);
    push("bad_fn", 4'd1, C_DECODE, ADD, 1'b0);
    push("bad_fn", 4'd6, C_EXR, NOP, 1'b1);
    step(3);

    rtype("sub", SUB);
    rtype("nor", NOR_);
    rtype("xor", XOR_);
    itype("addi", 6'b001000, ADD);
    itype("andi", 6'b001100, AND_);
    itype("ori", 6'b001101, OR_);
    itype("xori", 6'b001110, XOR_);

`ifdef MC_CTRL_MEM_WAIT_EN
    // Three stalled FETCH cycles, then a full lw: 5 + 3 cycles.
    opcode = 6'b100011;
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) push("fetch_wait", 4'd0, C_FETCHW, ADD, 1'b0);
    push("lw_wait", 4'd0, C_FETCH, ADD, 1'b0);
    push("lw_wait", 4'd1, C_DECODE, ADD, 1'b0);
    push("lw_wait", 4'd2, C_MADDR, ADD, 1'b0);
    push("lw_wait", 4'd3, C_MRD, NOP, 1'b0);
    push("lw_wait", 4'd4, C_MWB, NOP, 1'b0);
    step(3);
    mem_ready = 1'b1;
    step(5);
    cnt++;
`else
    // mem_ready is ignored: sw still takes four cycles with it low.
    mem_ready = 1'b0;
    opcode = 6'b101011;
    push("sw_noready", 4'd0, C_FETCH, ADD, 1'b0);
    push("sw_noready", 4'd1, C_DECODE, ADD, 1'b0);
    push("sw_noready", 4'd2, C_MADDR, ADD, 1'b0);
    push("sw_noready", 4'd5, C_MWR, NOP, 1'b0);
    step(4);
    cnt++;
    mem_ready = 1'b1;
`endif

    // Reset asserted in the middle of MEM_RD of a load.
    opcode = 6'b100011;
    push("lw_abort", 4'd0, C_FETCH, ADD, 1'b0);
    push("lw_abort", 4'd1, C_DECODE, ADD, 1'b0);
    push("lw_abort", 4'd2, C_MADDR, ADD, 1'b0);
    push("lw_abort", 4'd3, C_MRD, NOP, 1'b0);
    step(3);
    #6;
    do_reset();

    rtype("add_after_rst", ADD);
    opcode = 6'b000010;
    push("final_fetch", 4'd0, C_FETCH, ADD, 1'b0);
    step(1);
    step(2);

    n_checks++;
    if (q_exp.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: got %0d unchecked records, need 0", q_exp.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
